lsu: RTL and testbench

Load/store unit between the execute stage and `sram`. It accepts one memory request at a time from execute and converts it into a `sram` read or write transaction. It handles byte-lane placement, write masks and load sign/zero extension, then presents the result to write-back through a valid/ready handshake. Only one request is in flight at a time; `in_ready` is low until the result leaves.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_if.sv | 49 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu.sv | 116 +++++++++++
 tb/tb_lsu.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        RESP
    } lsu_state_t;

    // RV32 load/store size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a lane-0 access of each size
    localparam logic [7:0] WMASK_B = 8'h01;
    localparam logic [7:0] WMASK_H = 8'h03;
    localparam logic [7:0] WMASK_W = 8'h0F;

endpackage

// File: rtl/lsu_if.sv
// Bundle of execute request, write-back result and sram port signals around the LSU.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; sram_valid completes sram accesses.
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_misalign;

    logic        sram_ren;
    logic        sram_wen;
    logic [7:0]  sram_wmask;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_valid;
    logic        sram_receive_valid;

    // LSU side
    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        output in_ready,
        output out_valid, out_rdata, out_rd, out_misalign,
        input  out_ready,
        output sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata, sram_receive_valid,
        input  sram_rdata, sram_valid
    );

    // Execute / write-back / sram side
    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  out_valid, out_rdata, out_rd, out_misalign,
        output out_ready,
        input  sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata, sram_receive_valid,
        output sram_rdata, sram_valid
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane placement: store mask/data shifting, load extraction/extension, alignment check.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [7:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [4:0]  sh_amt;
    logic [31:0] rd_sh;
    logic [3:0]  base4;
    logic [3:0]  mask4;

    assign sh_amt   = {addr_lo, 3'b000};
    assign rd_sh    = rdata >> sh_amt;
    assign wdata_sh = wdata << sh_amt;

    // Decode size/sign: pick base mask, extend the shifted read word, flag misalignment
    always_comb begin
        base4     = WMASK_B[3:0];
        misalign  = 1'b0;
        rdata_ext = rd_sh;
        case (funct3)
            F3_B: begin
                base4     = WMASK_B[3:0];
                rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            F3_BU: begin
                base4     = WMASK_B[3:0];
                rdata_ext = {24'b0, rd_sh[7:0]};
            end
            F3_H: begin
                base4     = WMASK_H[3:0];
                misalign  = addr_lo[0];
                rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            F3_HU: begin
                base4     = WMASK_H[3:0];
                misalign  = addr_lo[0];
                rdata_ext = {16'b0, rd_sh[15:0]};
            end
            F3_W: begin
                base4     = WMASK_W[3:0];
                misalign  = |addr_lo;
                rdata_ext = rd_sh;
            end
            default: begin
                // Undefined size codes never reach sram
                misalign  = 1'b1;
                rdata_ext = 32'b0;
            end
        endcase
        mask4 = base4 << addr_lo;
        wmask = {4'b0000, mask4};
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: converts one execute-stage memory request into an sram read or write.
// Latency: load 2 cycles + sram read latency, store 2 cycles, misaligned/non-memory 1 cycle.
// Backpressure: one request in flight; in_ready stays low until out_valid&out_ready retires the result.
module lsu
    import lsu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    lsu_state_t  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [7:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;
    logic        is_mem;

    // In IDLE the aligner looks at the incoming request; afterwards at the latched one
    assign al_funct3  = (state == IDLE) ? bus.in_funct3    : funct3_q;
    assign al_addr_lo = (state == IDLE) ? bus.in_addr[1:0] : addr_lo_q;
    assign is_mem     = bus.in_ren | bus.in_wen;

    lsu_align u_align (
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (bus.in_wdata),
        .rdata     (bus.sram_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata),
        .misalign  (al_misalign)
    );

    assign bus.in_ready           = rst && (state == IDLE);
    // Read data is consumed in the very cycle sram presents it
    assign bus.sram_receive_valid = rst && (state == RD_WAIT) && bus.sram_valid;

    // Request FSM with registered sram strobes and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            funct3_q         <= 3'b0;
            addr_lo_q        <= 2'b0;
            bus.out_valid    <= 1'b0;
            bus.out_rdata    <= 32'b0;
            bus.out_rd       <= 5'b0;
            bus.out_misalign <= 1'b0;
            bus.sram_ren     <= 1'b0;
            bus.sram_wen     <= 1'b0;
            bus.sram_wmask   <= 8'b0;
            bus.sram_addr    <= 32'b0;
            bus.sram_wdata   <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        funct3_q         <= bus.in_funct3;
                        addr_lo_q        <= bus.in_addr[1:0];
                        bus.out_rd       <= bus.in_rd;
                        bus.out_rdata    <= 32'b0;
                        bus.out_misalign <= 1'b0;
                        if (!is_mem || al_misalign) begin
                            bus.out_misalign <= is_mem && al_misalign;
                            bus.out_valid    <= 1'b1;
                            state            <= RESP;
                        end else if (bus.in_wen) begin
                            // Store wins when both ren and wen are set
                            bus.sram_wen   <= 1'b1;
                            bus.sram_wmask <= al_wmask;
                            bus.sram_wdata <= al_wdata;
                            bus.sram_addr  <= {bus.in_addr[31:2], 2'b00};
                            state          <= WR;
                        end else begin
                            bus.sram_ren   <= 1'b1;
                            bus.sram_addr  <= {bus.in_addr[31:2], 2'b00};
                            state          <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    bus.sram_ren <= 1'b0;
                    state        <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.sram_valid) begin
                        bus.out_rdata <= al_rdata;
                        bus.out_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                WR: begin
                    bus.sram_wen   <= 1'b0;
                    bus.sram_wmask <= 8'b0;
                    if (bus.sram_valid) begin
                        bus.out_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized requests against a reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and variable sram read latency.
module tb_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if ifc ();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    // sram model: read data appears rd_lat cycles after the ren strobe, writes complete at once
    int          rd_lat = 1;
    int          rcnt;
    logic        rvld;
    logic [31:0] rdata_val = 32'h0;

    assign ifc.sram_rdata = rvld ? rdata_val : ~rdata_val;
    assign ifc.sram_valid = rvld | ifc.sram_wen;

    always @(posedge clk) begin
        if (!rst) begin
            rvld <= 1'b0;
            rcnt <= 0;
        end else if (ifc.sram_ren) begin
            if (rd_lat <= 1) rvld <= 1'b1;
            else rcnt <= rd_lat - 1;
        end else if (rcnt > 1) begin
            rcnt <= rcnt - 1;
        end else if (rcnt == 1) begin
            rcnt <= 0;
            rvld <= 1'b1;
        end else begin
            rvld <= 1'b0;
        end
    end

    // Bus monitor: counts strobes, captures sram-side values, tallies protocol violations
    int          ren_n = 0, wen_n = 0, rcv_n = 0, mon_bad = 0;
    logic        ren_prev = 1'b0;
    logic [31:0] cap_raddr = 32'h0, cap_waddr = 32'h0, cap_wdata = 32'h0;
    logic [7:0]  cap_wmask = 8'h0;

    always @(negedge clk) begin
        if (ifc.sram_ren) begin
            ren_n++;
            cap_raddr = ifc.sram_addr;
            if (ren_prev) mon_bad++;
        end
        if (ifc.sram_wen) begin
            wen_n++;
            cap_waddr = ifc.sram_addr;
            cap_wmask = ifc.sram_wmask;
            cap_wdata = ifc.sram_wdata;
        end else if (ifc.sram_wmask != 8'h0) begin
            mon_bad++;
        end
        if (ifc.sram_ren && ifc.sram_wen) mon_bad++;
        if (ifc.sram_receive_valid) begin
            rcv_n++;
            if (!ifc.sram_valid || ifc.sram_addr !== cap_raddr) mon_bad++;
        end
        if (rvld && ifc.sram_addr !== cap_raddr) mon_bad++;
        ren_prev = ifc.sram_ren;
    end

    typedef struct packed {
        int          lat;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        logic        rdy_before;
        logic        busy_rdy;
        logic        stable;
        logic        idle_after;
        int          nren;
        int          nwen;
        int          nrcv;
        int          bad;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int model_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = model_size(f3);
        if (sz == 0) return 1'b1;
        return (addr % 32'(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] w);
        logic [31:0] b, h, off;
        off = addr % 4;
        b = (w >> (8 * off)) % 256;
        h = (w >> (8 * off)) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver / observer ----------------
    task automatic do_txn(input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rword, input int lat, input int hold,
                          input string name, output obs_t o);
        int   s_ren, s_wen, s_rcv, s_bad, cyc;
        logic seen;
        o = '0;
        rd_lat    = lat;
        rdata_val = rword;
        s_ren = ren_n; s_wen = wen_n; s_rcv = rcv_n; s_bad = mon_bad;
        @(negedge clk);
        o.rdy_before  = ifc.in_ready;
        ifc.in_valid  = 1'b1;
        ifc.in_ren    = ren;
        ifc.in_wen    = wen;
        ifc.in_funct3 = f3;
        ifc.in_addr   = addr;
        ifc.in_wdata  = wdata;
        ifc.in_rd     = rd;
        @(posedge clk);
        #1;
        ifc.in_valid  = 1'b0;
        ifc.in_ren    = 1'($urandom);
        ifc.in_wen    = 1'($urandom);
        ifc.in_funct3 = 3'($urandom);
        ifc.in_addr   = $urandom;
        ifc.in_wdata  = $urandom;
        ifc.in_rd     = 5'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ifc.in_ready) o.busy_rdy = 1'b1;
            if (ifc.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid not seen in %0d cycles", name, cyc);
            o.lat = -1;
            return;
        end
        o.lat    = cyc;
        o.rdata  = ifc.out_rdata;
        o.rd     = ifc.out_rd;
        o.mis    = ifc.out_misalign;
        o.stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b1 || ifc.out_rdata !== o.rdata || ifc.out_rd !== o.rd ||
                ifc.out_misalign !== o.mis || ifc.in_ready !== 1'b0)
                o.stable = 1'b0;
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        o.idle_after = (ifc.in_ready === 1'b1) && (ifc.out_valid === 1'b0);
        o.nren  = ren_n - s_ren;
        o.nwen  = wen_n - s_wen;
        o.nrcv  = rcv_n - s_rcv;
        o.bad   = mon_bad - s_bad;
        o.raddr = cap_raddr;
        o.waddr = cap_waddr;
        o.wdata = cap_wdata;
        o.wmask = cap_wmask;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_ren = 1'b1; ifc.in_wen = 1'b0;
        ifc.in_funct3 = 3'd2; ifc.in_addr = 32'h10; ifc.in_wdata = 32'h0; ifc.in_rd = 5'd3;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_rdata !== 32'h0 ||
            ifc.out_rd !== 5'h0 || ifc.out_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rdy=%b vld=%b rdata=%h rd=%h mis=%b, want all 0",
                     ifc.in_ready, ifc.out_valid, ifc.out_rdata, ifc.out_rd, ifc.out_misalign);
        end
        checks++;
        if (ifc.sram_ren !== 1'b0 || ifc.sram_wen !== 1'b0 || ifc.sram_wmask !== 8'h0 ||
            ifc.sram_receive_valid !== 1'b0 || ifc.sram_addr !== 32'h0 || ifc.sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_sram: ren=%b wen=%b mask=%h rcv=%b addr=%h wdata=%h, want all 0",
                     ifc.sram_ren, ifc.sram_wen, ifc.sram_wmask, ifc.sram_receive_valid,
                     ifc.sram_addr, ifc.sram_wdata);
        end
        ifc.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b want 1", ifc.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        obs_t o;
        do_txn(1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0, 5'd7, 32'hDEAD_BEEF, 1, 0, "lw", o);
        checks++;
        if (o.lat !== 3 || o.rdata !== 32'hDEAD_BEEF || o.rd !== 5'd7 || o.mis !== 1'b0) begin
            errors++;
            $display("FAIL lw_result lat=%0d rdata=%h rd=%0d mis=%b want 3 deadbeef 7 0",
                     o.lat, o.rdata, o.rd, o.mis);
        end
        checks++;
        if (o.nren !== 1 || o.nrcv !== 1 || o.nwen !== 0 || o.raddr !== 32'h8000_0004 || o.bad !== 0) begin
            errors++;
            $display("FAIL lw_sram ren=%0d rcv=%0d wen=%0d addr=%h bad=%0d want 1 1 0 80000004 0",
                     o.nren, o.nrcv, o.nwen, o.raddr, o.bad);
        end
        checks++;
        if (o.rdy_before !== 1'b1 || o.busy_rdy !== 1'b0 || o.idle_after !== 1'b1) begin
            errors++;
            $display("FAIL lw_ready before=%b busy=%b after=%b want 1 0 1",
                     o.rdy_before, o.busy_rdy, o.idle_after);
        end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        do_txn(1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0, 5'd1, 32'h8012_3456, 1, 0, "lb", o);
        checks++;
        if (o.rdata !== 32'hFFFF_FF80 || o.lat !== 3) begin
            errors++;
            $display("FAIL lb rdata=%h lat=%0d want ffffff80 3", o.rdata, o.lat);
        end
        do_txn(1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0, 5'd2, 32'h8012_3456, 1, 0, "lbu", o);
        checks++;
        if (o.rdata !== 32'h0000_0080 || o.raddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL lbu rdata=%h addr=%h want 00000080 80000000", o.rdata, o.raddr);
        end
        do_txn(1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0, 5'd3, 32'h9ABC_1234, 1, 0, "lh", o);
        checks++;
        if (o.rdata !== 32'hFFFF_9ABC) begin
            errors++;
            $display("FAIL lh rdata=%h want ffff9abc", o.rdata);
        end
    endtask

    task automatic test_sh();
        obs_t o;
        do_txn(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 5'd4, 32'h0, 1, 0, "sh", o);
        checks++;
        if (o.wmask !== 8'h0C || o.wdata !== 32'hABCD_0000 || o.waddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sh_sram mask=%h wdata=%h addr=%h want 0c abcd0000 80000000",
                     o.wmask, o.wdata, o.waddr);
        end
        checks++;
        if (o.lat !== 2 || o.nwen !== 1 || o.nren !== 0 || o.rdata !== 32'h0 || o.mis !== 1'b0 || o.bad !== 0) begin
            errors++;
            $display("FAIL sh_result lat=%0d wen=%0d ren=%0d rdata=%h mis=%b bad=%0d want 2 1 0 0 0 0",
                     o.lat, o.nwen, o.nren, o.rdata, o.mis, o.bad);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_txn(1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0, 5'd9, 32'h1234_5678, 1, 0, "lw_mis", o);
        checks++;
        if (o.mis !== 1'b1 || o.rdata !== 32'h0 || o.lat !== 1 || o.nren !== 0 || o.nwen !== 0) begin
            errors++;
            $display("FAIL lw_misalign mis=%b rdata=%h lat=%0d ren=%0d wen=%0d want 1 0 1 0 0",
                     o.mis, o.rdata, o.lat, o.nren, o.nwen);
        end
        do_txn(1'b1, 1'b0, 3'd3, 32'h8000_0000, 32'h0, 5'd9, 32'h1234_5678, 1, 0, "undef_f3", o);
        checks++;
        if (o.mis !== 1'b1 || o.lat !== 1 || o.nren !== 0) begin
            errors++;
            $display("FAIL undef_f3 mis=%b lat=%0d ren=%0d want 1 1 0", o.mis, o.lat, o.nren);
        end
        do_txn(1'b0, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd12, 32'h0, 1, 0, "nonmem", o);
        checks++;
        if (o.mis !== 1'b0 || o.lat !== 1 || o.rd !== 5'd12 || o.nren !== 0 || o.nwen !== 0 || o.rdata !== 32'h0) begin
            errors++;
            $display("FAIL nonmem mis=%b lat=%0d rd=%0d ren=%0d wen=%0d rdata=%h want 0 1 12 0 0 0",
                     o.mis, o.lat, o.rd, o.nren, o.nwen, o.rdata);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_txn(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd21, 32'h8765_4321, 2, 5, "stall", o);
        checks++;
        if (o.stable !== 1'b1 || o.nren !== 1 || o.rdata !== 32'h0000_8765 || o.lat !== 4) begin
            errors++;
            $display("FAIL stall stable=%b ren=%0d rdata=%h lat=%0d want 1 1 00008765 4",
                     o.stable, o.nren, o.rdata, o.lat);
        end
    endtask

    task automatic test_rst_mid();
        obs_t o;
        int   s_ren;
        s_ren     = ren_n;
        rd_lat    = 30;
        rdata_val = 32'h5555_AAAA;
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_ren = 1'b1; ifc.in_wen = 1'b0;
        ifc.in_funct3 = 3'd2; ifc.in_addr = 32'h0000_0100; ifc.in_rd = 5'd5;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.sram_ren !== 1'b0 || ifc.sram_wen !== 1'b0 ||
            ifc.sram_wmask !== 8'h0 || ifc.sram_receive_valid !== 1'b0 || ifc.in_ready !== 1'b0 ||
            ren_n - s_ren !== 1) begin
            errors++;
            $display("FAIL rst_mid vld=%b ren=%b wen=%b mask=%h rcv=%b rdy=%b pulses=%0d want 0 0 0 0 0 0 1",
                     ifc.out_valid, ifc.sram_ren, ifc.sram_wen, ifc.sram_wmask,
                     ifc.sram_receive_valid, ifc.in_ready, ren_n - s_ren);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release rdy=%b vld=%b want 1 0", ifc.in_ready, ifc.out_valid);
        end
        @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'h0, 5'd6, 32'hC0FF_EE00, 1, 0, "after_rst", o);
        checks++;
        if (o.lat !== 3 || o.rdata !== 32'hC0FF_EE00 || o.nren !== 1) begin
            errors++;
            $display("FAIL after_rst lat=%0d rdata=%h ren=%0d want 3 c0ffee00 1", o.lat, o.rdata, o.nren);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rword, exp_rdata;
        logic [4:0]  rd;
        logic        mem, st, ld, mis;
        int          lat, hold, exp_lat, sz;
        for (int i = 0; i < 40; i++) begin
            op    = 2'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            wdata = $urandom;
            rword = $urandom;
            rd    = 5'($urandom);
            lat   = $urandom_range(1, 3);
            hold  = $urandom_range(0, 2);
            if (op == 2'b00) begin
                f3 = 3'd2;
                addr[1:0] = 2'b00;
            end else if (op[1] && (f3 == 3'd4 || f3 == 3'd5)) begin
                f3 = f3 - 3'd4;
            end
            mem = |op;
            st  = op[1];
            ld  = op[0] && !op[1];
            mis = mem && model_mis(f3, addr);
            sz  = model_size(f3);
            exp_lat   = (!mem || mis) ? 1 : (st ? 2 : 2 + lat);
            exp_rdata = (ld && !mis) ? model_load(f3, addr, rword) : 32'h0;
            do_txn(op[0], op[1], f3, addr, wdata, rd, rword, lat, hold, "rand", o);
            checks++;
            if (o.lat !== exp_lat || o.rdata !== exp_rdata || o.mis !== mis || o.rd !== rd) begin
                errors++;
                $display("FAIL rand%0d op=%b f3=%0d addr=%h lat=%0d/%0d rdata=%h/%h mis=%b/%b rd=%0d/%0d",
                         i, op, f3, addr, o.lat, exp_lat, o.rdata, exp_rdata, o.mis, mis, o.rd, rd);
            end
            checks++;
            if (o.nren !== ((ld && !mis) ? 1 : 0) || o.nrcv !== o.nren ||
                o.nwen !== ((st && !mis) ? 1 : 0) || o.bad !== 0 || o.stable !== 1'b1 ||
                o.busy_rdy !== 1'b0 || o.idle_after !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_proto ren=%0d rcv=%0d wen=%0d bad=%0d stable=%b busy=%b idle=%b",
                         i, o.nren, o.nrcv, o.nwen, o.bad, o.stable, o.busy_rdy, o.idle_after);
            end
            if (st && !mis) begin
                checks++;
                if (o.waddr !== {addr[31:2], 2'b00} ||
                    o.wmask !== 8'(((1 << sz) - 1) << (addr % 4)) ||
                    o.wdata !== 32'(wdata << (8 * (addr % 4)))) begin
                    errors++;
                    $display("FAIL rand%0d_store addr=%h mask=%h wdata=%h (req addr=%h f3=%0d wdata=%h)",
                             i, o.waddr, o.wmask, o.wdata, addr, f3, wdata);
                end
            end
            if (ld && !mis) begin
                checks++;
                if (o.raddr !== {addr[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rand%0d_raddr got %h want %h", i, o.raddr, {addr[31:2], 2'b00});
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_backpressure();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
